palette_loader: RTL and testbench

//  Transmit side of the custom-palette load stream consumed by video_mux. Takes the

---
 rtl/k7800_pkg.sv | 14 +
 rtl/palette_loader_byte_fifo.sv | 56 +++++
 rtl/palette_loader.sv | 134 +++++++++++++
 tb/tb_palette_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/k7800_pkg.sv
// Shared definitions for the 7800 core video path: palette geometry and loader states.
package k7800_pkg;

  localparam int unsigned PAL_BYTES   = 768;
  localparam int unsigned PAL_ENTRIES = 256;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD,
    FINISH
  } pal_state_t;

endpackage

// File: rtl/palette_loader_byte_fifo.sv
// Synchronous byte FIFO with registered read data and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (32'(count) == DEPTH);
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/palette_loader.sv
// Buffers the ioctl palette download and replays it to video_mux as a paced
// pal_load/pal_wr byte stream, padding short files to a whole RGB entry.
module palette_loader #(
  parameter logic [7:0]  PAL_INDEX  = 8'd2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WR_GAP     = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        pal_load,
  output logic        pal_wr,
  output logic [7:0]  pal_data,
  output logic [9:0]  pal_addr,
  output logic        pal_done,
  output logic        pal_err
);

  import k7800_pkg::*;

  localparam logic [9:0] CNT_FULL = 10'(PAL_BYTES);
  localparam logic [3:0] GAP_LOAD = 4'(WR_GAP);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

  pal_state_t state, state_nxt;

  logic          dl_match, dl_prev, dl_rise, start_pend, start_go;
  logic          wr_hit, addr_ok, accept, drop;
  logic          pop, pad_wr, emit, data_from_fifo;
  logic [9:0]    byte_cnt;
  logic [1:0]    phase;
  logic [3:0]    gap_cnt;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (accept),
    .din     (ioctl_dout),
    .pop     (pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // phase tracks byte_cnt mod 3 so padding needs no divider
  always_comb begin
    dl_match = ioctl_download && (ioctl_index == PAL_INDEX);
    dl_rise  = dl_match && !dl_prev;
    start_go = dl_match && (dl_rise || start_pend);
    wr_hit   = dl_match && ioctl_wr;
    addr_ok  = (ioctl_addr < 25'(PAL_BYTES));
    accept   = wr_hit && addr_ok;
    pop      = (state == STREAM) && !fifo_empty && (gap_cnt == '0) && (byte_cnt != CNT_FULL);
    pad_wr   = (state == PAD) && (gap_cnt == '0) && (phase != 2'd0);
    emit     = pop || pad_wr;
    drop     = (wr_hit && !addr_ok) || (accept && fifo_full && !pop);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_go) state_nxt = STREAM;
      STREAM: begin
        if (byte_cnt == CNT_FULL)         state_nxt = FINISH;
        else if (!dl_match && fifo_empty) state_nxt = (phase == 2'd0) ? FINISH : PAD;
      end
      PAD:     if (phase == 2'd0) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pal_load = (state != IDLE);
    pal_done = (state == FINISH) && (byte_cnt == CNT_FULL);
    pal_data = data_from_fifo ? fifo_dout : '0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev        <= 1'b0;
      start_pend     <= 1'b0;
      byte_cnt       <= '0;
      phase          <= '0;
      gap_cnt        <= '0;
      pal_wr         <= 1'b0;
      pal_addr       <= '0;
      pal_err        <= 1'b0;
      data_from_fifo <= 1'b0;
      ioctl_wait     <= 1'b0;
    end else begin
      dl_prev    <= dl_match;
      ioctl_wait <= (32'(fifo_count) >= FIFO_DEPTH - 1);

      // a start seen outside IDLE is held so pal_load still drops for a cycle
      if (state == IDLE)  start_pend <= 1'b0;
      else if (dl_rise)   start_pend <= 1'b1;

      if (emit)                gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;

      pal_wr <= emit;
      if (emit) begin
        pal_addr       <= byte_cnt;
        byte_cnt       <= byte_cnt + 10'd1;
        phase          <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        data_from_fifo <= pop;
      end

      if (state == IDLE && start_go) begin
        byte_cnt <= '0;
        phase    <= '0;
        pal_err  <= 1'b0;
      end
      if (state == STREAM && state_nxt != STREAM && byte_cnt != CNT_FULL) pal_err <= 1'b1;
      if (drop) pal_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_palette_loader.sv
// Scoreboard bench for palette_loader: a file-level model queues the expected
// pal_wr stream per download, and a negedge monitor checks what the DUT emits.
module tb_palette_loader;

  localparam logic [7:0]  PAL_INDEX  = 8'd2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned WR_GAP     = 1;
  localparam int          NBYTES     = 768;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        pal_load;
  logic        pal_wr;
  logic [7:0]  pal_data;
  logic [9:0]  pal_addr;
  logic        pal_done;
  logic        pal_err;

  palette_loader #(
    .PAL_INDEX  (PAL_INDEX),
    .FIFO_DEPTH (FIFO_DEPTH),
    .WR_GAP     (WR_GAP)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .pal_load       (pal_load),
    .pal_wr         (pal_wr),
    .pal_data       (pal_data),
    .pal_addr       (pal_addr),
    .pal_done       (pal_done),
    .pal_err        (pal_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] file_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int last_wr_cyc = -100;
  int fall_cyc = -100;
  int done_cnt = 0;
  bit saw_load = 0;
  bit saw_wait = 0;
  bit prev_load = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pal_wr is matched against the head of the scoreboard.
  always @(negedge clk_sys) begin
    exp_t e;
    cyc++;
    if (pal_load)   saw_load = 1;
    if (ioctl_wait) saw_wait = 1;
    if (prev_load && !pal_load) fall_cyc = cyc;
    prev_load = pal_load;
    if (pal_done) done_cnt++;
    if (pal_wr) begin
      check("load_during_wr", pal_load, 1);
      check("wr_spacing", (cyc - last_wr_cyc) >= int'(WR_GAP) + 1, 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wr: got addr %0d data %0h, expected no write", pal_addr, pal_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", pal_addr, e.addr);
        check("wr_data", pal_data, e.data);
      end
      last_wr_cyc = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference model: first 768 bytes in file order, short files zero-padded to a whole entry.
  task automatic build_expect();
    int n = file_q.size();
    int keep = (n < NBYTES) ? n : NBYTES;
    int padded = ((n + 2) / 3) * 3;
    for (int i = 0; i < keep; i++) exp_q.push_back({10'(i), file_q[i]});
    if (n < NBYTES)
      for (int i = n; i < padded; i++) exp_q.push_back({10'(i), 8'h00});
  endtask

  task automatic make_file(input int n, input int kind);
    file_q.delete();
    for (int i = 0; i < n; i++) file_q.push_back(kind == 0 ? 8'(i) : 8'($urandom));
  endtask

  task automatic send_byte(input int i, input bit honor);
    int k = 0;
    if (honor) begin
      while (ioctl_wait && k < 1000) begin
        tick();
        k++;
      end
      if (k >= 1000) check("wait_release", ioctl_wait, 0);
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(i);
    ioctl_dout = file_q[i];
    tick();
    ioctl_wr = 1'b0;
  endtask

  // kind 0: counting bytes every third cycle; 1: random bytes/gaps honouring wait; 2: back-to-back burst
  task automatic download(input logic [7:0] idx, input int n, input int kind);
    make_file(n, kind);
    if (idx == PAL_INDEX) build_expect();
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    repeat (2) tick();
    for (int i = 0; i < n; i++) begin
      send_byte(i, kind == 1);
      if (kind == 0) repeat (2) tick();
      if (kind == 1) repeat ($urandom_range(0, 3)) tick();
    end
    tick();
    ioctl_download = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int k = 0; k < 5000; k++) begin
      if (!pal_load && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    check(name, ok, 1);
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_load"}, pal_load, 0);
    check({tag, "_wr"},   pal_wr,   0);
    check({tag, "_data"}, pal_data, 0);
    check({tag, "_addr"}, pal_addr, 0);
    check({tag, "_done"}, pal_done, 0);
    check({tag, "_err"},  pal_err,  0);
    check({tag, "_wait"}, ioctl_wait, 0);
  endtask

  initial begin
    int d0;
    int nrand;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_outputs_zero("reset");

    // Full 768-byte load without backpressure
    saw_wait = 0;
    d0 = done_cnt;
    download(PAL_INDEX, NBYTES, 0);
    wait_idle("full_finish");
    check("full_done", done_cnt - d0, 1);
    check("full_err", pal_err, 0);
    check("full_load_tail", fall_cyc - last_wr_cyc, 2);
    check("full_no_wait", saw_wait, 0);

    // Eight-byte back-to-back burst: backpressure must rise, no byte lost
    saw_wait = 0;
    d0 = done_cnt;
    download(PAL_INDEX, 8, 2);
    check("burst_wait_seen", saw_wait, 1);
    wait_idle("burst_finish");
    check("burst_err", pal_err, 1);
    check("burst_done", done_cnt - d0, 0);

    // Short 100-byte file pads addresses 100 and 101
    d0 = done_cnt;
    download(PAL_INDEX, 100, 1);
    wait_idle("short_finish");
    check("short_err", pal_err, 1);
    check("short_done", done_cnt - d0, 0);

    // Oversized 800-byte file
    d0 = done_cnt;
    download(PAL_INDEX, 800, 1);
    wait_idle("long_finish");
    check("long_err", pal_err, 1);
    check("long_done", done_cnt - d0, 1);

    // Download for another target is ignored
    saw_load = 0;
    saw_wait = 0;
    download(8'h01, 50, 1);
    wait_idle("other_finish");
    check("other_no_load", saw_load, 0);
    check("other_no_wait", saw_wait, 0);

    // Random-length short file
    d0 = done_cnt;
    nrand = $urandom_range(1, NBYTES - 1);
    download(PAL_INDEX, nrand, 1);
    wait_idle("rand_finish");
    check("rand_err", pal_err, 1);
    check("rand_done", done_cnt - d0, 0);

    // Reset at byte 300, then a clean restart from address 0
    make_file(NBYTES, 1);
    build_expect();
    ioctl_download = 1'b1;
    ioctl_index    = PAL_INDEX;
    repeat (2) tick();
    for (int i = 0; i < 300; i++) send_byte(i, 1'b1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check_outputs_zero("midreset");
    exp_q.delete();
    reset = 1'b0;
    repeat (2) tick();
    d0 = done_cnt;
    download(PAL_INDEX, NBYTES, 1);
    wait_idle("restart_finish");
    check("restart_done", done_cnt - d0, 1);
    check("restart_err", pal_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
